jam_search_param: RTL
=====================

Name: jam_search_param

Overview:
Exhaustive job-assignment optimiser for N workers × N jobs. It walks all N! permutations in lexicographic order and reads each worker/job cost from an external combinational cost ROM. It reports the minimum total cost and how many permutations reach that minimum. This is the parametrised successor to the fixed 8×8 JAM engine, and adds a Start/Busy handshake, restartability, a saturating match counter and optional pruning.

Parameters:
N, 8, number of workers = number of jobs; legal range 2..8
IDX_W, 3, width of worker/job index; must be ≥ clog2(N)
COST_W, 7, width of one Cost entry
SUM_W, 10, accumulator/MinCost width; must hold N*(2^COST_W-1)
COUNT_W, 16, MatchCount width; saturates at all-ones

Ports:
CLK  in  1  clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
Start  in  1  begin search; sampled only in IDLE or DONE
Busy  out  1  high from the accepted Start until Valid rises
W  out  IDX_W  worker index presented to cost ROM
J  out  IDX_W  job index presented to cost ROM (= perm[W])
Cost  in  COST_W  ROM output for (W,J), combinational, sampled same cycle
MinCost  out  SUM_W  minimum total cost found
MatchCount  out  COUNT_W  number of permutations with total == MinCost
Valid  out  1  results final; held until next accepted Start

Behaviour:
- Reset (RST_N low, async): state=IDLE; perm[k]=k; W=0; J=0; sum=0; MinCost=all-ones; MatchCount=0; Valid=0; Busy=0.
- States: IDLE, CAL, CMP, SWAP, REV, DONE. All registered outputs; W,J,Busy,Valid come straight from flops.
- IDLE/DONE + Start=1 → CAL.
  - On entry: perm=identity, W=0, sum=0, MinCost=all-ones, MatchCount=0, Valid=0, Busy=1.
  - Start=0 holds the current state.
- CAL: each cycle, sum += Cost for the presented (W, J=perm[W]). W increments. After W=N-1 → CMP. Exactly N cycles.
- CMP (1 cycle):
  - If sum < MinCost: MinCost=sum, MatchCount=1.
  - Else if sum == MinCost: MatchCount+1, saturating at 2^COST_W... i.e. at 2^COUNT_W-1.
  - Pivot i = largest index with perm[i] < perm[i+1], found by a combinational priority scan.
  - No pivot (perm fully descending) → DONE. Otherwise → SWAP.
- SWAP: j = largest index > i with perm[j] > perm[i]. Exchange perm[i] and perm[j] → REV.
- REV: reverse perm[i+1..N-1] in one cycle. Reset W=0, sum=0 → CAL.
- Per permutation: N+3 cycles; the last permutation takes N+1 cycles.
  - Accepted Start edge to Valid high = (N!-1)(N+3)+N+1 cycles (pruning off).
- DONE: Valid=1, Busy=0, W/J hold last values. MinCost/MatchCount are stable.
- Tie rule: the first permutation always loads MinCost (all-ones > any legal sum). No ties are lost to ordering.
- Start while Busy=1 is ignored.
- RST_N assertion mid-search aborts immediately to the reset values; no partial results are retained.
- Widths: sum is SUM_W bits with no wrap permitted by the parameter rule; the comparison is unsigned.

Optional Feature:
JAM_PRUNE_EN
- Defined: in CAL, if (sum+Cost) > MinCost, abandon the current permutation.
  - Go straight to pivot evaluation: no MinCost/MatchCount update. No pivot → DONE; else → SWAP.
  - Equal partial sums are never pruned, so MatchCount is unchanged.
- Results must be bit-identical to the non-pruned build. Latency is data-dependent but never exceeds the non-pruned figure.
- Undefined: CAL always runs the full N cycles.

Test Plan:
- N=3, cost[w][j] = w*3+j (0..8), Start → MinCost=12, MatchCount=6 (every permutation sums to 12). Valid at cycle 5*6+4=34 after Start; Busy low after.
- N=4, cost = 0 on the diagonal, 5 elsewhere → MinCost=0, MatchCount=1. Valid at 23*7+5=166 cycles.
- N=8, all costs 0, COUNT_W=8 → MinCost=0, MatchCount=255 (saturated), Valid asserted. Second Start → identical result with Valid low during the run.
- N=4 run; pulse RST_N low at cycle 40 → all outputs at reset values within the same cycle. New Start yields correct results.
- Start held high throughout a run → no restart until DONE. Start in DONE clears Valid next cycle.
- JAM_PRUNE_EN built, N=5 random costs, seed-matched against the non-pruned build → equal MinCost/MatchCount, strictly fewer cycles.

Source files
------------

// File: rtl/jam_search_param.sv
// jam_search_param: exhaustive N x N job-assignment optimiser.
// Walks all N! permutations of perm[] in lexicographic order. For each one it
// accumulates cost(W, perm[W]) from an external combinational ROM, then tracks
// the minimum total and how many permutations reach it.
//
// Ports:
//   CLK        - clock, all state on the rising edge
//   RST_N      - asynchronous active-low reset
//   Start      - begin a search; only sampled in IDLE or DONE
//   Busy       - high from the accepted Start until Valid rises
//   W, J       - worker index / job index (perm[W]) presented to the cost ROM
//   Cost       - ROM output for (W, J), sampled in the same cycle
//   MinCost    - minimum total cost found
//   MatchCount - permutations whose total equals MinCost (saturating)
//   Valid      - results final; held until the next accepted Start
//
// Build option: define JAM_PRUNE_EN to abandon a permutation as soon as its
// partial sum exceeds MinCost. Results are identical; only latency changes.
module jam_search_param #(
    parameter int unsigned N       = 8,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned COST_W  = 7,
    parameter int unsigned SUM_W   = 10,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               Start,
    output logic               Busy,
    output logic [IDX_W-1:0]   W,
    output logic [IDX_W-1:0]   J,
    input  logic [COST_W-1:0]  Cost,
    output logic [SUM_W-1:0]   MinCost,
    output logic [COUNT_W-1:0] MatchCount,
    output logic               Valid
);

    typedef enum logic [2:0] {StIdle, StCal, StCmp, StSwap, StRev, StDone} state_e;

    state_e             r_state, w_state_d;
    logic [IDX_W-1:0]   r_perm [N];
    logic [IDX_W-1:0]   w_perm_d [N];
    logic [IDX_W-1:0]   r_w, w_w_d, r_j, w_j_d, r_piv, w_piv_d;
    logic [SUM_W-1:0]   r_sum, w_sum_d, r_min, w_min_d, w_sum_add;
    logic [COUNT_W-1:0] r_cnt, w_cnt_d;
    logic               r_busy, w_busy_d, r_valid, w_valid_d;
    logic               w_has_piv, w_last_w, w_prune;
    logic [IDX_W-1:0]   w_piv_scan, w_swap_j, w_swap_val, w_piv_val;

    assign w_sum_add = r_sum + SUM_W'(Cost);
    assign w_last_w  = (r_w == IDX_W'(N - 1));

`ifdef JAM_PRUNE_EN
    // Strictly greater only: equal partial sums may still tie MinCost.
    assign w_prune = (w_sum_add > r_min);
`else
    assign w_prune = 1'b0;
`endif

    // Pivot: largest i with perm[i] < perm[i+1]; later hits override earlier.
    always_comb begin
        w_has_piv  = 1'b0;
        w_piv_scan = '0;
        for (int k = 0; k < int'(N) - 1; k++) begin
            if (r_perm[k] < r_perm[k+1]) begin
                w_has_piv  = 1'b1;
                w_piv_scan = IDX_W'(k);
            end
        end
    end

    // Swap partner: largest j > pivot with perm[j] > perm[pivot].
    always_comb begin
        w_piv_val = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (IDX_W'(k) == r_piv) w_piv_val = r_perm[k];
        end
        w_swap_j   = r_piv;
        w_swap_val = w_piv_val;
        for (int k = 0; k < int'(N); k++) begin
            if (IDX_W'(k) > r_piv && r_perm[k] > w_piv_val) begin
                w_swap_j   = IDX_W'(k);
                w_swap_val = r_perm[k];
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_perm_d  = r_perm;
        w_w_d     = r_w;
        w_sum_d   = r_sum;
        w_min_d   = r_min;
        w_cnt_d   = r_cnt;
        w_piv_d   = r_piv;
        w_busy_d  = r_busy;
        w_valid_d = r_valid;
        unique case (r_state)
            StIdle, StDone: begin
                if (Start) begin
                    w_state_d = StCal;
                    for (int k = 0; k < int'(N); k++) w_perm_d[k] = IDX_W'(k);
                    w_w_d     = '0;
                    w_sum_d   = '0;
                    w_min_d   = '1;
                    w_cnt_d   = '0;
                    w_valid_d = 1'b0;
                    w_busy_d  = 1'b1;
                end
            end
            StCal: begin
                w_sum_d = w_sum_add;
                if (w_prune) begin
                    // Abandoned permutation: step straight to the next one.
                    w_piv_d = w_piv_scan;
                    if (w_has_piv) begin
                        w_state_d = StSwap;
                    end else begin
                        w_state_d = StDone;
                        w_busy_d  = 1'b0;
                        w_valid_d = 1'b1;
                    end
                end else if (w_last_w) begin
                    w_state_d = StCmp;
                end else begin
                    w_w_d = r_w + IDX_W'(1);
                end
            end
            StCmp: begin
                if (r_sum < r_min) begin
                    w_min_d = r_sum;
                    w_cnt_d = COUNT_W'(1);
                end else if (r_sum == r_min && r_cnt != '1) begin
                    w_cnt_d = r_cnt + COUNT_W'(1);
                end
                w_piv_d = w_piv_scan;
                if (w_has_piv) begin
                    w_state_d = StSwap;
                end else begin
                    w_state_d = StDone;
                    w_busy_d  = 1'b0;
                    w_valid_d = 1'b1;
                end
            end
            StSwap: begin
                for (int k = 0; k < int'(N); k++) begin
                    if (IDX_W'(k) == r_piv)         w_perm_d[k] = w_swap_val;
                    else if (IDX_W'(k) == w_swap_j) w_perm_d[k] = w_piv_val;
                end
                w_state_d = StRev;
            end
            StRev: begin
                // Tail perm[piv+1..N-1] reversed: slot k takes slot N+piv-k.
                for (int k = 0; k < int'(N); k++) begin
                    for (int m = 0; m < int'(N); m++) begin
                        if (IDX_W'(k) > r_piv && (k + m) == int'(N) + int'(r_piv)) begin
                            w_perm_d[k] = r_perm[m];
                        end
                    end
                end
                w_w_d     = '0;
                w_sum_d   = '0;
                w_state_d = StCal;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // J is registered as perm[W] of the next state so it stays a flop output.
    always_comb begin
        w_j_d = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (IDX_W'(k) == w_w_d) w_j_d = w_perm_d[k];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= StIdle;
            for (int k = 0; k < int'(N); k++) r_perm[k] <= IDX_W'(k);
            r_w     <= '0;
            r_j     <= '0;
            r_piv   <= '0;
            r_sum   <= '0;
            r_min   <= '1;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_perm  <= w_perm_d;
            r_w     <= w_w_d;
            r_j     <= w_j_d;
            r_piv   <= w_piv_d;
            r_sum   <= w_sum_d;
            r_min   <= w_min_d;
            r_cnt   <= w_cnt_d;
            r_busy  <= w_busy_d;
            r_valid <= w_valid_d;
        end
    end

    assign W          = r_w;
    assign J          = r_j;
    assign MinCost    = r_min;
    assign MatchCount = r_cnt;
    assign Busy       = r_busy;
    assign Valid      = r_valid;

endmodule
